// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared FSM state type and default parameters for the pushbutton interrupt controller
package irq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  localparam int IRQ_BASE_DEF = 5;
  localparam int DB_COUNT_DEF = 48000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stable-level debouncer for one button
// Debounce counter present only with IRQ_CTRL_DEBOUNCE_EN; otherwise level follows the synchronizer
module btn_debounce
  import irq_ctrl_pkg::*;
#(
  parameter int DB_W     = 16,
  parameter int DB_COUNT = DB_COUNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], btn_in};
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= sync_d;
`ifdef IRQ_CTRL_DEBOUNCE_EN
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d, differ, done;
  always_comb begin
    differ  = sync_q[1] != level_q;
    done    = differ && cnt_q == DB_W'(DB_COUNT - 1);
    cnt_d   = (differ && !done) ? cnt_q + 1'b1 : '0;
    level_d = done ? sync_q[1] : level_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  assign level = level_q;
`else
  assign level = sync_q[1];
`endif
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: debounced pushbutton interrupt controller, fixed priority + mask, one IRQ held until EOI
// Debouncing enabled by defining IRQ_CTRL_DEBOUNCE_EN
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC    = 3,
  parameter int IRQ_BASE = IRQ_BASE_DEF,
  parameter int DB_W     = 16,
  parameter int DB_COUNT = DB_COUNT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] btn_in,
  input  logic [N_SRC-1:0] mask,
  input  logic [31:0]      eoi,
  output logic [31:0]      irq,
  output logic [N_SRC-1:0] pending,
  output logic             busy
);
  localparam int CW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  logic [N_SRC-1:0] level, level_q, rise, req, clr, pending_q, pending_d;
  logic [CW-1:0]    cur_q, cur_d, sel;
  logic [31:0]      cur_bits;
  logic             eoi_hit;
  state_t           state_q, state_d;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    btn_debounce #(.DB_W(DB_W), .DB_COUNT(DB_COUNT)) u_db (
      .clk(clk), .reset(reset), .btn_in(btn_in[i]), .level(level[i])
    );
  end
  // set wins over the EOI clear so a press landing in the EOI cycle is serviced again
  always_comb begin
    rise     = level & ~level_q;
    req      = pending_q & mask;
    sel      = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (req[i]) sel = CW'(i);
    cur_bits = 32'(1) << (IRQ_BASE + int'(cur_q));
    eoi_hit  = state_q == ACTIVE && |(eoi & cur_bits);
    clr      = eoi_hit ? N_SRC'(1) << cur_q : '0;
    pending_d = (pending_q & ~clr) | rise;
  end
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ACTIVE;
        cur_d   = sel;
      end
      ACTIVE: state_d = eoi_hit ? GAP : ACTIVE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      level_q   <= '0;
      pending_q <= '0;
      cur_q     <= '0;
      state_q   <= IDLE;
    end else begin
      level_q   <= level;
      pending_q <= pending_d;
      cur_q     <= cur_d;
      state_q   <= state_d;
    end
  always_comb begin
    irq     = state_q == ACTIVE ? cur_bits : '0;
    busy    = state_q == ACTIVE;
    pending = pending_q;
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: table-driven scoreboard bench for irq_ctrl (DB_COUNT=4) plus an async-reset sequence
module tb_irq_ctrl;
`ifdef IRQ_CTRL_DEBOUNCE_EN
  localparam int DBC = 4;
`else
  localparam int DBC = 0;
`endif
  localparam int P = 3 + DBC;
  localparam int I = 4 + DBC;
  localparam logic [31:0] B5 = 32'h20, B6 = 32'h40, B7 = 32'h80;
  typedef struct {
    logic [2:0]  btn;
    logic [2:0]  mask;
    logic [31:0] eoi;
    logic [31:0] irq;
    logic [2:0]  pend;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int n_vec = 0, n_miss = 0, mon_idx = 0;
  logic        clk = 1'b0, reset = 1'b1;
  logic [2:0]  btn_in = '0, mask = 3'b111;
  logic [31:0] eoi = '0;
  logic [31:0] irq;
  logic [2:0]  pending;
  logic        busy;
  always #5 clk = ~clk;
  irq_ctrl #(.N_SRC(3), .IRQ_BASE(5), .DB_W(4), .DB_COUNT(4)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .mask(mask), .eoi(eoi),
    .irq(irq), .pending(pending), .busy(busy)
  );
  function automatic void add(input int n, input logic [2:0] b, input logic [2:0] m,
                              input logic [31:0] e, input logic [31:0] x, input logic [2:0] p);
    for (int k = 0; k < n; k++) vecs.push_back('{b, m, e, x, p});
  endfunction
  task automatic check(input string name, input logic [31:0] irq_x, input logic [2:0] pend_x);
    n_vec++;
    if (irq !== irq_x || pending !== pend_x || busy !== (irq_x != 0)) begin
      n_miss++;
      $display("FAIL %s: got irq=%h pending=%b busy=%b, expected irq=%h pending=%b busy=%b",
               name, irq, pending, busy, irq_x, pend_x, irq_x != 0);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      vec_t v;
      v = sb.pop_front();
      check($sformatf("vec%0d", mon_idx), v.irq, v.pend);
      mon_idx++;
    end
  initial begin
    repeat (2) @(negedge clk);
    check("reset", '0, '0);
    reset = 1'b0;
    // single press on source 0, serviced by EOI
    add(P - 1, 3'b001, 3'b111, 0, 0, 3'b000);
    add(1, 3'b001, 3'b111, 0, 0, 3'b001);
    add(2, 3'b001, 3'b111, 0, B5, 3'b001);
    add(1, 3'b001, 3'b111, B5, 0, 3'b000);
    add(2, 3'b001, 3'b111, 0, 0, 3'b000);
    add(DBC + 4, 3'b000, 3'b111, 0, 0, 3'b000);
`ifdef IRQ_CTRL_DEBOUNCE_EN
    add(3, 3'b010, 3'b111, 0, 0, 3'b000);
    add(DBC + 4, 3'b000, 3'b111, 0, 0, 3'b000);
`endif
    // simultaneous presses on sources 0 and 2
    add(P - 1, 3'b101, 3'b111, 0, 0, 3'b000);
    add(1, 3'b101, 3'b111, 0, 0, 3'b101);
    add(1, 3'b101, 3'b111, 0, B5, 3'b101);
    add(1, 3'b101, 3'b111, B5, 0, 3'b100);
    add(1, 3'b101, 3'b111, 0, 0, 3'b100);
    add(2, 3'b101, 3'b111, 0, B7, 3'b100);
    add(1, 3'b101, 3'b111, B7, 0, 3'b000);
    add(2, 3'b101, 3'b111, 0, 0, 3'b000);
    add(DBC + 4, 3'b000, 3'b111, 0, 0, 3'b000);
    // masked source latches pending, delivered after unmask
    add(P - 1, 3'b010, 3'b101, 0, 0, 3'b000);
    add(3, 3'b010, 3'b101, 0, 0, 3'b010);
    add(1, 3'b010, 3'b111, 0, B6, 3'b010);
    add(1, 3'b010, 3'b111, B6, 0, 3'b000);
    add(2, 3'b010, 3'b111, 0, 0, 3'b000);
    add(DBC + 4, 3'b000, 3'b111, 0, 0, 3'b000);
    // re-press whose pending set lands in the EOI cycle
    add(P - 1, 3'b001, 3'b111, 0, 0, 3'b000);
    add(1, 3'b001, 3'b111, 0, 0, 3'b001);
    add(2, 3'b001, 3'b111, 0, B5, 3'b001);
    add(DBC + 3, 3'b000, 3'b111, 0, B5, 3'b001);
    add(DBC + 2, 3'b001, 3'b111, 0, B5, 3'b001);
    add(1, 3'b001, 3'b111, B5, 0, 3'b001);
    add(1, 3'b001, 3'b111, 0, 0, 3'b001);
    add(2, 3'b001, 3'b111, 0, B5, 3'b001);
    add(1, 3'b001, 3'b111, B5, 0, 3'b000);
    add(2, 3'b001, 3'b111, 0, 0, 3'b000);
    add(DBC + 4, 3'b000, 3'b111, 0, 0, 3'b000);
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      btn_in = vecs[k].btn;
      mask   = vecs[k].mask;
      eoi    = vecs[k].eoi;
      @(posedge clk);
      sb.push_back(vecs[k]);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    // asynchronous reset while ACTIVE
    btn_in = 3'b001;
    repeat (I) @(negedge clk);
    check("rst_pre", B5, 3'b001);
    #2 reset = 1'b1;
    #1 check("rst_async", '0, '0);
    btn_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (DBC + 8) begin
      @(negedge clk);
      check("rst_after", '0, '0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Pushbutton interrupt controller for the picoRV32 SoC. Takes raw asynchronous button inputs, synchronizes and debounces them, and latches press events as pending interrupts. Raises one CPU interrupt line at a time, chosen by fixed priority and a software mask, and holds it until the CPU signals end-of-interrupt. Sits between the board pins and the `irq` input of the vargen core, replacing the direct pin-to-`irq_5..7` wiring.

## Interface
- `N_SRC`, 3: number of button sources.
- `IRQ_BASE`, 5: CPU IRQ number of source 0; source i maps to `irq[IRQ_BASE+i]`.
- `DB_W`, 16: debounce counter width.
- `DB_COUNT`, 48000: consecutive stable samples required to accept a level change (3 ms at 16 MHz). Must be at least 1.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_in`  in  N_SRC  raw button levels, active-high, asynchronous to `clk`.
- `mask`  in  N_SRC  1 = source enabled for delivery.
- `eoi`  in  32  picoRV32 end-of-interrupt vector.
- `irq`  out  32  picoRV32 interrupt vector. Only bits `IRQ_BASE..IRQ_BASE+N_SRC-1` are driven; all other bits are 0.
- `pending`  out  N_SRC  latched, not-yet-serviced press events.
- `busy`  out  1  high while an interrupt is asserted.

## Operation
- Per source: a 2-FF synchronizer feeds a debouncer. The debouncer feeds a rising-edge detector on the debounced level.
- Debounce:
  - The counter increments while the synchronized value differs from the stable level, and clears when they match.
  - When the counter equals `DB_COUNT-1` and the values still differ, the stable level updates and the counter clears.
- A debounced rising edge sets `pending[i]`. Falling edges are ignored.
- Masking:
  - Masked sources still latch `pending`; they are never selected for delivery.
  - Unmasking later delivers them.
- FSM states:
  - `IDLE`: if any `pending & mask` bit is set, select the lowest index (source 0 highest priority), register it as `cur`, and go to `ACTIVE`.
  - `ACTIVE`: drive `irq[IRQ_BASE+cur]` = 1 and `busy` = 1. When `eoi[IRQ_BASE+cur]` = 1, clear `pending[cur]` and go to `GAP`. Masking `cur` while in `ACTIVE` does not drop `irq`.
  - `GAP`: one cycle with `irq` = 0, so the CPU sees a deassertion. Then go to `IDLE`.
- Same-cycle set and clear of `pending[cur]`: set wins, and the source is serviced again.
- Repeated presses while a source is already pending collapse into one event.
- `eoi` bits for non-current IRQs are ignored.
- Reset values: all outputs 0, state `IDLE`, `pending` = 0, counters = 0, stable levels = 0, synchronizer flops = 0. Reset asserted mid-`ACTIVE` drops `irq` immediately (asynchronously).

## Timing
- Raw level change on `btn_in[i]` at edge 0 (held stable):
  - synchronized at edge 2;
  - stable level updates at edge 2+DB_COUNT;
  - `pending[i]` set at edge 3+DB_COUNT;
  - `irq` high at edge 4+DB_COUNT, if in `IDLE` and unmasked.
- `eoi` sampled at edge n: `irq` low at edge n+1 (`GAP`); the next `irq` can rise at edge n+3.
- `irq` and `busy` are registered outputs; no combinational path from inputs to outputs.
- Debounce glitch: a level change shorter than `DB_COUNT` synchronized cycles produces no event.

## Configuration
- `IRQ_CTRL_DEBOUNCE_EN` defined: debouncer instantiated as described.
- Not defined: the stable level equals the synchronizer output. `DB_W` and `DB_COUNT` are unused, and latency becomes raw edge to `irq` = 4 cycles (`DB_COUNT` treated as 0 in the timing formulas).

## Structure
- Package `irq_ctrl_pkg`:
  - state type (`IDLE`, `ACTIVE`, `GAP`);
  - default constants for `IRQ_BASE` and `DB_COUNT`.
- Sub-module `btn_debounce`: one source (synchronizer + counter + stable level), instantiated `N_SRC` times with a generate loop. The edge detect, pending register, arbiter and FSM live in `irq_ctrl`.

## Test plan
All scenarios use `DB_COUNT`=4.
- Reset mid-`ACTIVE`: assert `reset` while `irq[5]`=1 -> `irq`=0, `pending`=0 and `busy`=0 within the same cycle; no IRQ after release without a new press.
- Single press: `btn_in`=3'b001 held, `mask`=3'b111 -> `irq[5]` rises exactly 8 cycles later. Pulse `eoi[5]` -> `irq`=0 next cycle and `pending`=0.
- Glitch: `btn_in[1]` high for 3 cycles -> `pending` remains 0 and `irq` stays 0.
- Simultaneous presses: sources 0 and 2 in the same cycle -> `irq[5]` first. After `eoi[5]`: one low cycle, then `irq[7]`. `pending` goes 3'b101 -> 3'b100 -> 3'b000.
- Mask: `mask`=3'b101, press source 1 -> `pending`=3'b010 and no `irq`. Set `mask`=3'b111 -> `irq[6]` asserted the next cycle.
- Re-press during service: source 0 released and pressed again (debounced) while `ACTIVE` on source 0, with the new edge landing in the `eoi` cycle -> `pending[0]` stays 1 and `irq[5]` reasserts after `GAP`.
